// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bundle: decoder control and ID datapath in, EX copies,
// stall and halt status out. The master side is the core (decoder / hazard
// consumers); the slave side is the id_ex_stage register itself.
// Optional perf counters appear only when ID_EX_PERF_CNT_EN is defined.
interface id_ex_stage_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PC_W   = 32
);

  // ID-side inputs to the stage
  logic              id_valid;
  logic [6:0]        id_opcode;
  logic              id_alusrc;
  logic              id_memtoreg;
  logic              id_regwrite;
  logic              id_memread;
  logic              id_memwrite;
  logic              id_rtypeid;
  logic              id_branch;
  logic              id_jal;
  logic [1:0]        id_aluop;
  logic [PC_W-1:0]   id_pc;
  logic [DATA_W-1:0] id_rd1;
  logic [DATA_W-1:0] id_rd2;
  logic [DATA_W-1:0] id_imm;
  logic [4:0]        id_rs1;
  logic [4:0]        id_rs2;
  logic [4:0]        id_rd;
  logic [2:0]        id_funct3;
  logic [6:0]        id_funct7;
  logic              flush;

  // Stage outputs
  logic              stall_o;
  logic              ex_valid;
  logic [6:0]        ex_opcode;
  logic              ex_alusrc;
  logic              ex_memtoreg;
  logic              ex_regwrite;
  logic              ex_memread;
  logic              ex_memwrite;
  logic              ex_rtypeid;
  logic              ex_branch;
  logic              ex_jal;
  logic [1:0]        ex_aluop;
  logic [PC_W-1:0]   ex_pc;
  logic [DATA_W-1:0] ex_rd1;
  logic [DATA_W-1:0] ex_rd2;
  logic [DATA_W-1:0] ex_imm;
  logic [4:0]        ex_rs1;
  logic [4:0]        ex_rs2;
  logic [4:0]        ex_rd;
  logic [2:0]        ex_funct3;
  logic [6:0]        ex_funct7;
  logic              ex_halt;
  logic              halted_o;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0]       perf_stall_cnt;
  logic [31:0]       perf_flush_cnt;
`endif

  modport master (
    output id_valid, id_opcode, id_alusrc, id_memtoreg, id_regwrite, id_memread,
           id_memwrite, id_rtypeid, id_branch, id_jal, id_aluop, id_pc, id_rd1,
           id_rd2, id_imm, id_rs1, id_rs2, id_rd, id_funct3, id_funct7, flush,
    input  stall_o, ex_valid, ex_opcode, ex_alusrc, ex_memtoreg, ex_regwrite,
           ex_memread, ex_memwrite, ex_rtypeid, ex_branch, ex_jal, ex_aluop, ex_pc,
           ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7,
           ex_halt, halted_o
`ifdef ID_EX_PERF_CNT_EN
    , input perf_stall_cnt, perf_flush_cnt
`endif
  );

  modport slave (
    input  id_valid, id_opcode, id_alusrc, id_memtoreg, id_regwrite, id_memread,
           id_memwrite, id_rtypeid, id_branch, id_jal, id_aluop, id_pc, id_rd1,
           id_rd2, id_imm, id_rs1, id_rs2, id_rd, id_funct3, id_funct7, flush,
    output stall_o, ex_valid, ex_opcode, ex_alusrc, ex_memtoreg, ex_regwrite,
           ex_memread, ex_memwrite, ex_rtypeid, ex_branch, ex_jal, ex_aluop, ex_pc,
           ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7,
           ex_halt, halted_o
`ifdef ID_EX_PERF_CNT_EN
    , output perf_stall_cnt, perf_flush_cnt
`endif
  );

endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the 5-stage RISC-V core.
// Captures the decoder control bundle and ID datapath, detects load-use
// hazards (stall + bubble), applies branch/jump flushes and sequences HALT
// (opcode 7'b1111111) through a drain window before reporting halted_o.
// Optional: define ID_EX_PERF_CNT_EN to add saturating stall/flush counters.
module id_ex_stage #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned PC_W         = 32,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input logic          clk,
  input logic          reset,
  id_ex_stage_if.slave bus
);

  localparam logic [6:0] HaltOpcode = 7'b1111111;

  localparam logic [1:0] StRun    = 2'd0;
  localparam logic [1:0] StDrain  = 2'd1;
  localparam logic [1:0] StHalted = 2'd2;

  localparam int unsigned CntW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DRAIN_CYCLES - 1);

  // FSM state
  logic [1:0]      r_state;
  logic [CntW-1:0] r_drain_cnt;
  logic [1:0]      w_state_nxt;
  logic [CntW-1:0] w_drain_cnt_nxt;

  // EX registers
  logic              r_ex_valid;
  logic              r_ex_halt;
  logic [6:0]        r_ex_opcode;
  logic              r_ex_alusrc;
  logic              r_ex_memtoreg;
  logic              r_ex_regwrite;
  logic              r_ex_memread;
  logic              r_ex_memwrite;
  logic              r_ex_rtypeid;
  logic              r_ex_branch;
  logic              r_ex_jal;
  logic [1:0]        r_ex_aluop;
  logic [PC_W-1:0]   r_ex_pc;
  logic [DATA_W-1:0] r_ex_rd1;
  logic [DATA_W-1:0] r_ex_rd2;
  logic [DATA_W-1:0] r_ex_imm;
  logic [4:0]        r_ex_rs1;
  logic [4:0]        r_ex_rs2;
  logic [4:0]        r_ex_rd;
  logic [2:0]        r_ex_funct3;
  logic [6:0]        r_ex_funct7;

  // Decode of this cycle's action
  logic w_run;
  logic w_haz;
  logic w_stall;
  logic w_capture;
  logic w_id_halt;
  logic w_halt_in;
  logic w_ctrl_en;

  // Hazard detection and per-edge action select (reset > flush > haz > normal)
  always_comb begin
    w_run     = (r_state == StRun);
    w_haz     = r_ex_valid & r_ex_memread & (r_ex_rd != 5'd0) &
                ((r_ex_rd == bus.id_rs1) | (r_ex_rd == bus.id_rs2)) & bus.id_valid;
    w_stall   = w_haz & ~bus.flush & w_run;
    // Outside RUN every edge is a bubble, so capture implies RUN
    w_capture = w_run & ~bus.flush & ~w_haz;
    w_id_halt = bus.id_valid & (bus.id_opcode == HaltOpcode);
    w_halt_in = w_capture & w_id_halt;
    // HALT carries no control bits; the decoder's view of it is discarded
    w_ctrl_en = w_capture & bus.id_valid & ~w_id_halt;
  end

  // HALT drain sequencing: RUN -> DRAIN (count) -> HALTED (sticky)
  always_comb begin
    w_state_nxt     = r_state;
    w_drain_cnt_nxt = r_drain_cnt;
    case (r_state)
      StRun: begin
        if (w_halt_in) begin
          w_state_nxt     = StDrain;
          w_drain_cnt_nxt = '0;
        end
      end
      StDrain: begin
        if (r_drain_cnt == CntLast) begin
          w_state_nxt = StHalted;
        end else begin
          w_drain_cnt_nxt = r_drain_cnt + CntW'(1);
        end
      end
      StHalted: begin
        w_state_nxt = StHalted;
      end
      default: begin
        w_state_nxt     = StRun;
        w_drain_cnt_nxt = '0;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StRun;
      r_drain_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= w_drain_cnt_nxt;
    end
  end

  // Valid and control bits: captured only on a real, non-bubble edge
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex_valid    <= 1'b0;
      r_ex_halt     <= 1'b0;
      r_ex_alusrc   <= 1'b0;
      r_ex_memtoreg <= 1'b0;
      r_ex_regwrite <= 1'b0;
      r_ex_memread  <= 1'b0;
      r_ex_memwrite <= 1'b0;
      r_ex_rtypeid  <= 1'b0;
      r_ex_branch   <= 1'b0;
      r_ex_jal      <= 1'b0;
      r_ex_aluop    <= 2'b00;
    end else begin
      r_ex_valid    <= w_capture & bus.id_valid;
      r_ex_halt     <= w_halt_in;
      r_ex_alusrc   <= w_ctrl_en & bus.id_alusrc;
      r_ex_memtoreg <= w_ctrl_en & bus.id_memtoreg;
      r_ex_regwrite <= w_ctrl_en & bus.id_regwrite;
      r_ex_memread  <= w_ctrl_en & bus.id_memread;
      r_ex_memwrite <= w_ctrl_en & bus.id_memwrite;
      r_ex_rtypeid  <= w_ctrl_en & bus.id_rtypeid;
      r_ex_branch   <= w_ctrl_en & bus.id_branch;
      r_ex_jal      <= w_ctrl_en & bus.id_jal;
      r_ex_aluop    <= w_ctrl_en ? bus.id_aluop : 2'b00;
    end
  end

  // Datapath fields: loaded on capture, held across bubbles
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex_opcode <= '0;
      r_ex_pc     <= '0;
      r_ex_rd1    <= '0;
      r_ex_rd2    <= '0;
      r_ex_imm    <= '0;
      r_ex_rs1    <= '0;
      r_ex_rs2    <= '0;
      r_ex_rd     <= '0;
      r_ex_funct3 <= '0;
      r_ex_funct7 <= '0;
    end else if (w_capture) begin
      r_ex_opcode <= bus.id_opcode;
      r_ex_pc     <= bus.id_pc;
      r_ex_rd1    <= bus.id_rd1;
      r_ex_rd2    <= bus.id_rd2;
      r_ex_imm    <= bus.id_imm;
      r_ex_rs1    <= bus.id_rs1;
      r_ex_rs2    <= bus.id_rs2;
      r_ex_rd     <= bus.id_rd;
      r_ex_funct3 <= bus.id_funct3;
      r_ex_funct7 <= bus.id_funct7;
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] r_perf_stall_cnt;
  logic [31:0] r_perf_flush_cnt;

  // Saturating event counters
  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_stall_cnt <= '0;
      r_perf_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_perf_stall_cnt != 32'hFFFF_FFFF)) begin
        r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
      end
      if (bus.flush && w_run && (r_perf_flush_cnt != 32'hFFFF_FFFF)) begin
        r_perf_flush_cnt <= r_perf_flush_cnt + 32'd1;
      end
    end
  end

  assign bus.perf_stall_cnt = r_perf_stall_cnt;
  assign bus.perf_flush_cnt = r_perf_flush_cnt;
`endif

  assign bus.stall_o     = w_stall;
  assign bus.halted_o    = (r_state == StHalted);
  assign bus.ex_valid    = r_ex_valid;
  assign bus.ex_halt     = r_ex_halt;
  assign bus.ex_opcode   = r_ex_opcode;
  assign bus.ex_alusrc   = r_ex_alusrc;
  assign bus.ex_memtoreg = r_ex_memtoreg;
  assign bus.ex_regwrite = r_ex_regwrite;
  assign bus.ex_memread  = r_ex_memread;
  assign bus.ex_memwrite = r_ex_memwrite;
  assign bus.ex_rtypeid  = r_ex_rtypeid;
  assign bus.ex_branch   = r_ex_branch;
  assign bus.ex_jal      = r_ex_jal;
  assign bus.ex_aluop    = r_ex_aluop;
  assign bus.ex_pc       = r_ex_pc;
  assign bus.ex_rd1      = r_ex_rd1;
  assign bus.ex_rd2      = r_ex_rd2;
  assign bus.ex_imm      = r_ex_imm;
  assign bus.ex_rs1      = r_ex_rs1;
  assign bus.ex_rs2      = r_ex_rs2;
  assign bus.ex_rd       = r_ex_rd;
  assign bus.ex_funct3   = r_ex_funct3;
  assign bus.ex_funct7   = r_ex_funct7;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline boundary of the 5-stage RISC-V core, directly downstream of the main decoder.
- Registers the decoder's control bundle and the ID datapath fields into the EX stage.
- Detects load-use hazards, stalls IF/ID and injects a bubble.
- Applies branch/jump flushes, and runs the HALT drain state machine (HALT opcode 7'b1111111).

Parameters:
- DATA_W, 32, width of register operands and immediate
- PC_W, 32, width of program counter
- DRAIN_CYCLES, 3, cycles after HALT enters EX before halted_o asserts (lets older instructions retire)

Ports:
- clk  in  1  core clock, all state on rising edge
- reset  in  1  synchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_opcode  in  7  opcode of ID instruction
- id_alusrc, id_memtoreg, id_regwrite, id_memread, id_memwrite, id_rtypeid, id_branch, id_jal  in  1 each  decoder control outputs
- id_aluop  in  2  decoder ALUOp
- id_pc  in  PC_W  PC of ID instruction
- id_rd1, id_rd2, id_imm  in  DATA_W each  register operands, sign-extended immediate
- id_rs1, id_rs2, id_rd  in  5 each  register indices
- id_funct3  in  3
- id_funct7  in  7
- flush  in  1  branch/jump resolved taken in EX; squash ID instruction
- stall_o  out  1  hold PC and IF/ID register this cycle (combinational)
- ex_valid  out  1  EX holds a real instruction
- ex_* (one per id_ control/data input above, same width)  out  registered EX copies
- ex_halt  out  1  EX holds the HALT instruction
- halted_o  out  1  core halted, sticky until reset

Behaviour:
- Reset: every ex_* output, ex_valid, ex_halt and halted_o are 0. State is RUN. Drain counter is 0.
- Latency: one cycle, ID to EX.
- Hazard (combinational): haz = ex_valid & ex_memread & (ex_rd != 0) & (ex_rd == id_rs1 | ex_rd == id_rs2) & id_valid.
- stall_o = haz & ~flush & (state == RUN).
- Per-edge priority is reset > flush > haz > normal:
  - flush: load a bubble (ex_valid = 0, all control outputs 0, ex_halt = 0). Data fields are don't-care and are held.
  - haz: load a bubble. The ID instruction is re-presented next cycle because stall_o held IF/ID.
  - normal: capture all id_* into ex_*, with ex_valid = id_valid.
  - Any captured control bit with id_valid = 0 is forced to 0.
- HALT capture: in RUN, if the normal case applies and id_opcode == 7'b1111111 with id_valid = 1:
  - ex_halt = 1, ex_valid = 1, all other control bits forced 0 (id_branch from the decoder is ignored for HALT).
  - State moves to DRAIN, counter = 0.
- DRAIN:
  - Every edge loads a bubble. stall_o = 0. flush is ignored.
  - The counter increments each cycle; when it reaches DRAIN_CYCLES-1, state moves to HALTED.
- HALTED:
  - halted_o = 1. Every edge loads a bubble. stall_o = 0.
  - Exit only through reset.
- Flushed HALT: a HALT arriving in the same cycle as flush is squashed and does not enter DRAIN.
- Reset mid-operation (including DRAIN or HALTED) returns to RUN with all outputs 0 on the next edge.
- x0 rule: rd == 0 never triggers a hazard. ex_regwrite passes through unchanged for rd == 0 (suppression is the register file's job).

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- When defined, adds two outputs, each 32 bits, reset to 0, saturating at 32'hFFFFFFFF:
  - perf_stall_cnt: increments each cycle stall_o = 1.
  - perf_flush_cnt: increments each cycle flush = 1 with state == RUN.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Passthrough: id_valid = 1, R-type (id_regwrite = 1, id_aluop = 2'b10, id_rtypeid = 1, id_rd = 5, id_rd1 = 32'h11, id_rd2 = 32'h22) -> next cycle ex_valid = 1, ex_aluop = 2'b10, ex_rd = 5, ex_rd1 = 32'h11, ex_rd2 = 32'h22; stall_o = 0 throughout.
- Load-use: lw x7 in EX (ex_memread = 1, ex_rd = 7), then ID add with rs2 = 7 -> stall_o = 1 for exactly one cycle, bubble in EX, add captured on the following edge. Repeat with ex_rd = 0 -> no stall.
- Flush vs stall: hazard condition true and flush = 1 in the same cycle -> stall_o = 0, EX gets a bubble (ex_valid = 0, ex_memwrite = 0).
- HALT: ID opcode 7'h7F, DRAIN_CYCLES = 3 -> ex_halt = 1 for one cycle, halted_o = 1 exactly 3 cycles after ex_halt rises, then stays 1 with ex_valid = 0 while id_valid keeps toggling.
- Reset mid-DRAIN: assert reset 1 cycle into DRAIN -> all outputs 0 after the edge, halted_o never asserts, a normal instruction passes 2 cycles later.
- With ID_EX_PERF_CNT_EN: 4 load-use stalls and 2 flushes -> perf_stall_cnt = 4, perf_flush_cnt = 2. Without the macro the bench compiles with no perf ports.
